sqrt_seq: RTL and testbench
===========================

Name: sqrt_seq

Overview:
- Parametrised sequential integer square-root unit. Successor to the fixed 16-bit sqrt block.
- Computes floor(sqrt(D)) and the remainder D - Q^2 with a digit-by-digit restoring algorithm, one result bit per clock.
- Adds a start/busy/ready handshake, back-to-back operation and an optional round-to-nearest mode.
- Sits as a standalone arithmetic coprocessor behind a controller that issues start and samples Q/remainder on ready.

Parameters:
- DW, 16, radicand width. Must be even and >= 4.
- QW, DW/2, root width. Derived localparam, not overridable.
- CW, $clog2(QW+1), iteration-counter width. Derived localparam.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge of clk.
- D  input  DW  unsigned radicand; sampled only on the accepting edge.
- Q  output  QW  root result, registered.
- remainder  output  QW+1  D - Q^2 (unrounded), registered.
- round_up  output  1  1 when Q was incremented by rounding; constant 0 without the feature.
- busy  output  1  high while iterating.
- ready  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Q, remainder, round_up, busy, ready all 0.
  - Internal working registers and iteration counter all 0.
  - Reset asserted mid-operation aborts immediately; no ready is produced for the aborted request.
- States:
  - IDLE: busy=0, ready=0.
  - CALC: busy=1, ready=0.
  - DONE: busy=0, ready=1.
- Transitions:
  - IDLE, start=1 -> CALC. D is captured into shift register dreg. Working root and working remainder are cleared; iter = QW-1.
  - IDLE, start=0 -> IDLE.
  - CALC, iter != 0 -> CALC. One iteration per edge; iter decrements.
  - CALC, iter == 0 -> DONE. Last iteration is performed; Q, remainder and round_up outputs are written on this same edge.
  - DONE, start=1 -> CALC. New D is captured (back-to-back operation).
  - DONE, start=0 -> IDLE.
- start while in CALC is ignored (not queued). D changes during CALC have no effect.
- Iteration step, using a QW+2-bit working remainder r and a QW-bit working root w:
  - r' = (r << 2) | dreg[DW-1:DW-2]; dreg <<= 2.
  - t = (w << 2) | 1, zero-extended to QW+2 bits.
  - If r' >= t: r = r' - t, w = (w << 1) | 1.
  - Else: r = r', w = w << 1.
- Latency: the accepting edge is edge 0; ready is high during the cycle after edge QW (QW+1 edges total). Throughput is one result per QW+1 cycles with continuous start.
- Outputs Q, remainder and round_up hold their value until the next completion edge. They are valid from the ready cycle onward, including while the next operation is in CALC.
- Width rule: the final remainder is <= 2Q, so it always fits in QW+1 bits. It is stored as the low QW+1 bits of r.
- D = 0 is legal: Q=0, remainder=0, full latency still applies (no early exit).

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined:
  - On the completion edge, if remainder > Q (i.e. D > Q^2+Q) and Q != all-ones, output Q+1 and set round_up=1.
  - If Q is all-ones, Q saturates (no increment) and round_up=0.
  - remainder always reports the unrounded D - floor^2.
  - Latency is unchanged.
- Undefined: Q is the floor result; round_up is tied to 0; no compare logic is synthesised.

Test Plan:
- DW=16, reset, start with D=127 -> ready pulses exactly 9 cycles after the accepting edge; Q=11, remainder=6, busy high for 8 cycles.
- D=0, then D=144, then D=65535 issued back-to-back via start held high in DONE -> results (0,0), (12,0), (255,510) with ready every 9 cycles and no IDLE gap.
- start with D=100, pulse start again with D=9 on the 3rd CALC cycle -> second start ignored; result Q=10, remainder=0; only one ready.
- start with D=50000, assert reset on the 4th CALC cycle -> outputs and busy go 0 immediately (asynchronously); no ready. A following start with D=49 -> Q=7, remainder=0.
- SQRT_ROUND_EN defined:
  - D=133 -> Q=12, remainder=12, round_up=1.
  - D=127 -> Q=11, round_up=0.
  - D=65535 -> Q=255 (saturated), remainder=510, round_up=0.
- DW=8 instance, D=255 -> Q=15, remainder=30, ready 5 cycles after accept.

Source files
------------

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - sequential restoring integer square root, one root bit per clock
// Optional round-to-nearest on completion: define SQRT_ROUND_EN.
module sqrt_seq #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   D,
  output logic [DW/2-1:0] Q,
  output logic [DW/2:0]   remainder,
  output logic            round_up,
  output logic            busy,
  output logic            ready
);

  localparam int QW = DW / 2;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_dreg;
  logic [QW+1:0]   r_rem;
  logic [QW-1:0]   r_root;
  logic [CW-1:0]   r_iter;

  logic [QW+1:0]   w_rshift;
  logic [QW+1:0]   w_trial;
  logic            w_ge;
  logic [QW+1:0]   w_rem_nx;
  logic [QW-1:0]   w_root_nx;
  logic [QW-1:0]   w_q_out;
  logic            w_rup;
  logic            w_accept;

  // Restoring step: bring down the next radicand digit pair and try subtracting 4w+1.
  assign w_rshift  = (r_rem << 2) | {{QW{1'b0}}, r_dreg[DW-1:DW-2]};
  assign w_trial   = {r_root, 2'b01};
  assign w_ge      = (w_rshift >= w_trial);
  assign w_rem_nx  = w_ge ? (w_rshift - w_trial) : w_rshift;
  assign w_root_nx = (r_root << 1) | {{(QW-1){1'b0}}, w_ge};

`ifdef SQRT_ROUND_EN
  logic w_round;
  assign w_round = ({1'b0, w_root_nx} < w_rem_nx[QW:0]) && (w_root_nx != {QW{1'b1}});
  assign w_q_out = w_root_nx + {{(QW-1){1'b0}}, w_round};
  assign w_rup   = w_round;
`else
  assign w_q_out = w_root_nx;
  assign w_rup   = 1'b0;
`endif

  assign w_accept = start && (r_state != S_CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dreg    <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_iter    <= '0;
      Q         <= '0;
      remainder <= '0;
      round_up  <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_dreg <= r_dreg << 2;
          r_rem  <= w_rem_nx;
          r_root <= w_root_nx;
          if (r_iter == '0) begin
            r_state   <= S_DONE;
            Q         <= w_q_out;
            remainder <= w_rem_nx[QW:0];
            round_up  <= w_rup;
            busy      <= 1'b0;
            ready     <= 1'b1;
          end else begin
            r_iter <= r_iter - 1'b1;
          end
        end
        default: begin
          ready <= 1'b0;
          if (w_accept) begin
            r_state <= S_CALC;
            r_dreg  <= D;
            r_rem   <= '0;
            r_root  <= '0;
            r_iter  <= CW'(QW - 1);
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// tb/tb_sqrt_seq.sv - self-checking bench for sqrt_seq (DW=16 and DW=8 instances)
module tb_sqrt_seq;

  localparam int DW  = 16;
  localparam int QW  = DW / 2;
  localparam int DW8 = 8;
  localparam int QW8 = DW8 / 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [DW-1:0]   D;
  logic [QW-1:0]   Q;
  logic [QW:0]     remainder;
  logic            round_up, busy, ready;

  logic            start8;
  logic [DW8-1:0]  D8;
  logic [QW8-1:0]  Q8;
  logic [QW8:0]    remainder8;
  logic            round_up8, busy8, ready8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_seq #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .D(D), .Q(Q), .remainder(remainder),
    .round_up(round_up), .busy(busy), .ready(ready)
  );

  sqrt_seq #(.DW(DW8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .D(D8), .Q(Q8), .remainder(remainder8),
    .round_up(round_up8), .busy(busy8), .ready(ready8)
  );

  function automatic int unsigned isqrt(input int unsigned d);
    int unsigned q = 0;
    while ((q + 1) * (q + 1) <= d) q++;
    return q;
  endfunction

  // Expected (Q, remainder, round_up) from plain arithmetic.
  task automatic model(input int unsigned d, input int qw,
                       output int unsigned eq, output int unsigned er, output bit eu);
    int unsigned fl;
    fl = isqrt(d);
    er = d - fl * fl;
    eq = fl;
    eu = 1'b0;
`ifdef SQRT_ROUND_EN
    if (er > fl && fl != (1 << qw) - 1) begin
      eq = fl + 1;
      eu = 1'b1;
    end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at #1 after an edge and wait for its ready.
  task automatic run_op(input logic [DW-1:0] d, input string tag);
    int unsigned eq, er;
    bit eu;
    int lat, bcnt;
    model(d, QW, eq, er, eu);
    start = 1'b1;
    D = d;
    tick();
    start = 1'b0;
    D = $urandom;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!ready && lat < 40) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
    n_vec++;
    if (lat !== QW) begin
      n_err++;
      $display("FAIL %s latency d=%0d got %0d exp %0d", tag, d, lat, QW);
    end
    n_vec++;
    if (bcnt !== QW) begin
      n_err++;
      $display("FAIL %s busy_cycles d=%0d got %0d exp %0d", tag, d, bcnt, QW);
    end
    n_vec++;
    if (Q !== QW'(eq) || remainder !== (QW+1)'(er) || round_up !== eu) begin
      n_err++;
      $display("FAIL %s result d=%0d got q=%0d r=%0d u=%0b exp q=%0d r=%0d u=%0b",
               tag, d, Q, remainder, round_up, eq, er, eu);
    end
    tick();
    n_vec++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready_pulse got ready=%0b busy=%0b exp 0 0", tag, ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; D = '0; start8 = 1'b0; D8 = '0;
    repeat (2) tick();
    n_vec++;
    if (Q !== '0 || remainder !== '0 || round_up !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got q=%0d r=%0d u=%0b b=%0b rdy=%0b exp all 0",
               Q, remainder, round_up, busy, ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_op(16'd127, "d127");
    run_op(16'd133, "d133");
    run_op(16'd0,   "d0");
    run_op(16'd65535, "dmax");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [0:5];
    int unsigned eq, er;
    bit eu;
    int gap;
    vals[0] = 16'd0; vals[1] = 16'd144; vals[2] = 16'd65535;
    for (int i = 3; i < 6; i++) vals[i] = DW'($urandom);
    start = 1'b1;
    D = vals[0];
    tick();
    for (int i = 0; i < 6; i++) begin
      D = (i < 5) ? vals[i+1] : '0;
      if (i == 5) start = 1'b0;
      gap = 0;
      while (!ready && gap < 40) begin
        tick();
        gap++;
      end
      model(vals[i], QW, eq, er, eu);
      n_vec++;
      if (gap !== QW || Q !== QW'(eq) || remainder !== (QW+1)'(er) || round_up !== eu) begin
        n_err++;
        $display("FAIL b2b[%0d] d=%0d got gap=%0d q=%0d r=%0d u=%0b exp gap=%0d q=%0d r=%0d u=%0b",
                 i, vals[i], gap, Q, remainder, round_up, QW, eq, er, eu);
      end
      tick();
      n_vec++;
      if (i < 5 && busy !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_no_gap[%0d] got busy=%0b exp 1", i, busy);
      end
    end
    start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_ignore_start();
    int lat, nrdy;
    start = 1'b1; D = 16'd100;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; D = 16'd9;
    tick();
    start = 1'b0; D = 16'd9;
    lat = 3;
    while (!ready && lat < 40) begin
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== QW || Q !== 8'd10 || remainder !== 9'd0) begin
      n_err++;
      $display("FAIL ignore_start got lat=%0d q=%0d r=%0d exp lat=%0d q=10 r=0", lat, Q, remainder, QW);
    end
    nrdy = 0;
    for (int i = 0; i < 2 * QW + 4; i++) begin
      tick();
      if (ready || busy) nrdy++;
    end
    n_vec++;
    if (nrdy !== 0) begin
      n_err++;
      $display("FAIL ignore_start_single got %0d extra active cycles exp 0", nrdy);
    end
  endtask

  task automatic test_abort();
    int nrdy;
    start = 1'b1; D = 16'd50000;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || ready !== 1'b0 || Q !== '0 || remainder !== '0 || round_up !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async got b=%0b rdy=%0b q=%0d r=%0d u=%0b exp all 0",
               busy, ready, Q, remainder, round_up);
    end
    tick();
    reset = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 2 * QW; i++) begin
      tick();
      if (ready || busy) nrdy++;
    end
    n_vec++;
    if (nrdy !== 0) begin
      n_err++;
      $display("FAIL abort_no_ready got %0d active cycles exp 0", nrdy);
    end
    run_op(16'd49, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_op(DW'($urandom), "rand");
    for (int i = 0; i < 6; i++) run_op(DW'(i * i + $urandom_range(0, 2 * i)), "square");
  endtask

  task automatic test_dw8();
    logic [DW8-1:0] vals [0:3];
    int unsigned eq, er;
    bit eu;
    int lat;
    vals[0] = 8'd255; vals[1] = 8'd0; vals[2] = DW8'($urandom); vals[3] = DW8'($urandom);
    for (int i = 0; i < 4; i++) begin
      model(vals[i], QW8, eq, er, eu);
      start8 = 1'b1; D8 = vals[i];
      tick();
      start8 = 1'b0;
      lat = 0;
      while (!ready8 && lat < 20) begin
        tick();
        lat++;
      end
      n_vec++;
      if (lat !== QW8 || Q8 !== QW8'(eq) || remainder8 !== (QW8+1)'(er) || round_up8 !== eu) begin
        n_err++;
        $display("FAIL dw8[%0d] d=%0d got lat=%0d q=%0d r=%0d u=%0b exp lat=%0d q=%0d r=%0d u=%0b",
                 i, vals[i], lat, Q8, remainder8, round_up8, QW8, eq, er, eu);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_random();
    test_dw8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
